// File: rtl/mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu
// Memory stage that sits directly behind the execute-stage ALU. Plain ALU
// results are registered and handed to writeback one cycle later. Load-word
// and store-word instructions use the word-aligned ALU result as an address
// and run a req/ready handshake on the data memory port. Execute is stalled
// while that access is outstanding. If memory never answers, the access
// gives up after TIMEOUT wait cycles and raises a sticky bus error.
//
// Ports
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   valid_e, alu_op_e,         instruction presented by execute
//   alu_out_e, store_data_e,
//   rd_e, reg_write_e
//   stall_m                    execute must hold its outputs this cycle
//   dmem_req, dmem_we,         data memory request (registered)
//   dmem_addr, dmem_wdata
//   dmem_ready, dmem_rdata     data memory completion and read data
//   valid_w, wb_data_w,        one result per instruction to writeback
//   rd_w, reg_write_w
//   bus_err_m                  sticky memory timeout flag
// ---------------------------------------------------------------------------
module mem_stage_lsu #(
  parameter logic [4:0] OP_LW   = 5'd21,
  parameter logic [4:0] OP_SW   = 5'd22,
  parameter int         TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_e,
  input  logic [4:0]  alu_op_e,
  input  logic [31:0] alu_out_e,
  input  logic [31:0] store_data_e,
  input  logic [4:0]  rd_e,
  input  logic        reg_write_e,
  output logic        stall_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        valid_w,
  output logic [31:0] wb_data_w,
  output logic [4:0]  rd_w,
  output logic        reg_write_w,
  output logic        bus_err_m
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  rdCap_q, rdCap_d;
  logic        regWrCap_q, regWrCap_d;
  logic        dmemReq_q, dmemReq_d;
  logic        dmemWe_q, dmemWe_d;
  logic [31:0] dmemAddr_q, dmemAddr_d;
  logic [31:0] dmemWdata_q, dmemWdata_d;
  logic        validW_q, validW_d;
  logic [31:0] wbData_q, wbData_d;
  logic [4:0]  rdW_q, rdW_d;
  logic        regWriteW_q, regWriteW_d;
  logic        busErr_q, busErr_d;

  logic isMemOp;
  logic lastWait;

  assign isMemOp  = (alu_op_e == OP_LW) || (alu_op_e == OP_SW);
  assign lastWait = (cnt_q == CNT_LAST);

  // Execute is held only while the access is still open after this cycle;
  // in the completion or timeout cycle it is released so the next
  // instruction is presented when this stage is back in IDLE.
  assign stall_m = (state_q == WAIT) && !dmem_ready && !lastWait;

  assign dmem_req    = dmemReq_q;
  assign dmem_we     = dmemWe_q;
  assign dmem_addr   = dmemAddr_q;
  assign dmem_wdata  = dmemWdata_q;
  assign valid_w     = validW_q;
  assign wb_data_w   = wbData_q;
  assign rd_w        = rdW_q;
  assign reg_write_w = regWriteW_q;
  assign bus_err_m   = busErr_q;

  // Next-state and output-register logic. valid_w and reg_write_w default
  // low so every result is a single-cycle pulse; everything else holds.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdCap_d     = rdCap_q;
    regWrCap_d  = regWrCap_q;
    dmemReq_d   = dmemReq_q;
    dmemWe_d    = dmemWe_q;
    dmemAddr_d  = dmemAddr_q;
    dmemWdata_d = dmemWdata_q;
    validW_d    = 1'b0;
    wbData_d    = wbData_q;
    rdW_d       = rdW_q;
    regWriteW_d = 1'b0;
    busErr_d    = busErr_q;

    case (state_q)
      IDLE: begin
        if (valid_e) begin
          if (isMemOp) begin
            rdCap_d     = rd_e;
            regWrCap_d  = reg_write_e;
            dmemAddr_d  = {alu_out_e[31:2], 2'b00};
            dmemWdata_d = store_data_e;
            dmemWe_d    = (alu_op_e == OP_SW);
            dmemReq_d   = 1'b1;
            cnt_d       = 8'd0;
            state_d     = WAIT;
          end else begin
            // Writes to x0 are suppressed here so writeback never has to.
            validW_d    = 1'b1;
            wbData_d    = alu_out_e;
            rdW_d       = rd_e;
            regWriteW_d = reg_write_e && (rd_e != 5'd0);
          end
        end
      end

      WAIT: begin
        if (dmem_ready) begin
          dmemReq_d = 1'b0;
          validW_d  = 1'b1;
          rdW_d     = rdCap_q;
          if (!dmemWe_q) begin
            wbData_d    = dmem_rdata;
            regWriteW_d = regWrCap_q && (rdCap_q != 5'd0);
          end
          state_d = IDLE;
        end else if (lastWait) begin
          // Abandon the access: retire the instruction without a register
          // write and latch the error until the next reset.
          dmemReq_d = 1'b0;
          busErr_d  = 1'b1;
          validW_d  = 1'b1;
          rdW_d     = rdCap_q;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      rdCap_q     <= 5'd0;
      regWrCap_q  <= 1'b0;
      dmemReq_q   <= 1'b0;
      dmemWe_q    <= 1'b0;
      dmemAddr_q  <= 32'd0;
      dmemWdata_q <= 32'd0;
      validW_q    <= 1'b0;
      wbData_q    <= 32'd0;
      rdW_q       <= 5'd0;
      regWriteW_q <= 1'b0;
      busErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdCap_q     <= rdCap_d;
      regWrCap_q  <= regWrCap_d;
      dmemReq_q   <= dmemReq_d;
      dmemWe_q    <= dmemWe_d;
      dmemAddr_q  <= dmemAddr_d;
      dmemWdata_q <= dmemWdata_d;
      validW_q    <= validW_d;
      wbData_q    <= wbData_d;
      rdW_q       <= rdW_d;
      regWriteW_q <= regWriteW_d;
      busErr_q    <= busErr_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_lsu
// Bench for mem_stage_lsu: directed scenarios with hand-computed values,
// then randomized instruction/memory traffic compared every cycle against a
// transaction-level model of the memory stage.
// ---------------------------------------------------------------------------
module tb_mem_stage_lsu;

  localparam logic [4:0] OP_LW   = 5'd21;
  localparam logic [4:0] OP_SW   = 5'd22;
  localparam int         TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic        valid_e;
  logic [4:0]  alu_op_e;
  logic [31:0] alu_out_e;
  logic [31:0] store_data_e;
  logic [4:0]  rd_e;
  logic        reg_write_e;
  logic        stall_m;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        valid_w;
  logic [31:0] wb_data_w;
  logic [4:0]  rd_w;
  logic        reg_write_w;
  logic        bus_err_m;

  int passCount  = 0;
  int checkCount = 0;

  mem_stage_lsu #(.OP_LW(OP_LW), .OP_SW(OP_SW), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_e      (valid_e),
    .alu_op_e     (alu_op_e),
    .alu_out_e    (alu_out_e),
    .store_data_e (store_data_e),
    .rd_e         (rd_e),
    .reg_write_e  (reg_write_e),
    .stall_m      (stall_m),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_ready   (dmem_ready),
    .dmem_rdata   (dmem_rdata),
    .valid_w      (valid_w),
    .wb_data_w    (wb_data_w),
    .rd_w         (rd_w),
    .reg_write_w  (reg_write_w),
    .bus_err_m    (bus_err_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a failure line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: actual 0x%08h required 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Drive every execute/memory input at once.
  task automatic applyStimulus(input logic v, input logic [4:0] op, input logic [31:0] alu,
                               input logic [31:0] sd, input logic [4:0] rd, input logic rw,
                               input logic rdy, input logic [31:0] rdata);
    valid_e      = v;
    alu_op_e     = op;
    alu_out_e    = alu;
    store_data_e = sd;
    rd_e         = rd;
    reg_write_e  = rw;
    dmem_ready   = rdy;
    dmem_rdata   = rdata;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Transaction-level model: an outstanding access is a record plus a count
  // of how many wait cycles it has already consumed.
  // -------------------------------------------------------------------------
  typedef struct {
    logic        isStore;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
  } memTxn_t;

  logic        modelLive = 1'b0;
  logic        mPending;
  memTxn_t     mTxn;
  int          mWaited;
  logic        eReq, eWe, eValid, eRw, eErr;
  logic [31:0] eAddr, eWdata, eWb;
  logic [4:0]  eRd;

  always @(posedge clk) begin
    eValid <= 1'b0;
    eRw    <= 1'b0;
    if (!rst_n) begin
      modelLive <= 1'b1;
      mPending  <= 1'b0;
      mWaited   <= 0;
      eReq <= 1'b0; eWe <= 1'b0; eAddr <= '0; eWdata <= '0;
      eWb  <= '0;   eRd <= '0;   eErr  <= 1'b0;
    end else if (mPending) begin
      if (dmem_ready) begin
        mPending <= 1'b0;
        eReq     <= 1'b0;
        eValid   <= 1'b1;
        eRd      <= mTxn.rd;
        if (!mTxn.isStore) begin
          eWb <= dmem_rdata;
          eRw <= mTxn.rw && (mTxn.rd != 5'd0);
        end
      end else if (mWaited + 1 == TIMEOUT) begin
        mPending <= 1'b0;
        eReq     <= 1'b0;
        eErr     <= 1'b1;
        eValid   <= 1'b1;
        eRd      <= mTxn.rd;
      end else begin
        mWaited <= mWaited + 1;
      end
    end else if (valid_e) begin
      if (alu_op_e == OP_LW || alu_op_e == OP_SW) begin
        mPending     <= 1'b1;
        mWaited      <= 0;
        mTxn.isStore <= (alu_op_e == OP_SW);
        mTxn.addr    <= alu_out_e & 32'hFFFF_FFFC;
        mTxn.data    <= store_data_e;
        mTxn.rd      <= rd_e;
        mTxn.rw      <= reg_write_e;
        eReq   <= 1'b1;
        eWe    <= (alu_op_e == OP_SW);
        eAddr  <= alu_out_e & 32'hFFFF_FFFC;
        eWdata <= store_data_e;
      end else begin
        eValid <= 1'b1;
        eWb    <= alu_out_e;
        eRd    <= rd_e;
        eRw    <= reg_write_e && (rd_e != 5'd0);
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (modelLive) begin
      checkOutput("stall_m",     {31'd0, stall_m},
                  {31'd0, mPending && !dmem_ready && (mWaited != TIMEOUT - 1)});
      checkOutput("dmem_req",    {31'd0, dmem_req},    {31'd0, eReq});
      checkOutput("dmem_we",     {31'd0, dmem_we},     {31'd0, eWe});
      checkOutput("dmem_addr",   dmem_addr,            eAddr);
      checkOutput("dmem_wdata",  dmem_wdata,           eWdata);
      checkOutput("valid_w",     {31'd0, valid_w},     {31'd0, eValid});
      checkOutput("wb_data_w",   wb_data_w,            eWb);
      checkOutput("rd_w",        {27'd0, rd_w},        {27'd0, eRd});
      checkOutput("reg_write_w", {31'd0, reg_write_w}, {31'd0, eRw});
      checkOutput("bus_err_m",   {31'd0, bus_err_m},   {31'd0, eErr});
    end
  end

  initial begin
    int noReadyLeft;
    rst_n = 1'b0;
    applyStimulus(0, 5'd0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    @(negedge clk);
    checkOutput("lit reset valid_w",  {31'd0, valid_w},  0);
    checkOutput("lit reset dmem_req", {31'd0, dmem_req}, 0);
    checkOutput("lit reset addr",     dmem_addr,         0);
    rst_n = 1'b1;

    // Three back-to-back ALU results.
    tick();
    applyStimulus(1, 5'd1, 32'h5, 0, 5'd3, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      checkOutput("lit alu valid_w", {31'd0, valid_w},     1);
      checkOutput("lit alu wb",      wb_data_w,            32'h5);
      checkOutput("lit alu rw",      {31'd0, reg_write_w}, 1);
      checkOutput("lit alu stall",   {31'd0, stall_m},     0);
    end
    applyStimulus(0, 5'd0, 0, 0, 0, 0, 0, 0);
    tick();
    @(negedge clk);
    checkOutput("lit idle valid_w", {31'd0, valid_w}, 0);

    // LW with ready on the third wait cycle.
    applyStimulus(1, OP_LW, 32'h1007, 0, 5'd4, 1, 0, 0);
    tick();
    applyStimulus(0, 5'd0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("lit lw addr",   dmem_addr,         32'h1004);
    checkOutput("lit lw we",     {31'd0, dmem_we},  0);
    checkOutput("lit lw req",    {31'd0, dmem_req}, 1);
    checkOutput("lit lw stall1", {31'd0, stall_m},  1);
    tick();
    @(negedge clk);
    checkOutput("lit lw stall2", {31'd0, stall_m},  1);
    tick();
    applyStimulus(0, 5'd0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("lit lw stall3", {31'd0, stall_m},  0);
    tick();
    applyStimulus(0, 5'd0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("lit lw valid_w", {31'd0, valid_w},     1);
    checkOutput("lit lw wb",      wb_data_w,            32'hDEAD_BEEF);
    checkOutput("lit lw rw",      {31'd0, reg_write_w}, 1);
    checkOutput("lit lw rd",      {27'd0, rd_w},        4);
    checkOutput("lit lw req off", {31'd0, dmem_req},    0);

    // SW ready immediately, ALU op follows without a bubble.
    applyStimulus(1, OP_SW, 32'h20, 32'h1234_5678, 5'd7, 1, 0, 0);
    tick();
    applyStimulus(1, 5'd2, 32'h99, 0, 5'd5, 1, 1, 32'h0BAD_0BAD);
    @(negedge clk);
    checkOutput("lit sw we",    {31'd0, dmem_we}, 1);
    checkOutput("lit sw wdata", dmem_wdata,       32'h1234_5678);
    checkOutput("lit sw stall", {31'd0, stall_m}, 0);
    tick();
    applyStimulus(1, 5'd2, 32'h99, 0, 5'd5, 1, 0, 0);
    @(negedge clk);
    checkOutput("lit sw valid_w", {31'd0, valid_w},     1);
    checkOutput("lit sw rw",      {31'd0, reg_write_w}, 0);
    checkOutput("lit sw wb kept", wb_data_w,            32'hDEAD_BEEF);
    tick();
    applyStimulus(0, 5'd0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("lit follow valid_w", {31'd0, valid_w}, 1);
    checkOutput("lit follow wb",      wb_data_w,        32'h99);

    // LW to x0 never writes the register file.
    applyStimulus(1, OP_LW, 32'h40, 0, 5'd0, 1, 0, 0);
    tick();
    applyStimulus(0, 5'd0, 0, 0, 0, 0, 1, 32'h5555_AAAA);
    tick();
    applyStimulus(0, 5'd0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("lit x0 valid_w", {31'd0, valid_w},     1);
    checkOutput("lit x0 rw",      {31'd0, reg_write_w}, 0);

    // Timeout: sixteen wait cycles, stall drops on the last one.
    applyStimulus(1, OP_LW, 32'h80, 0, 5'd9, 1, 0, 0);
    tick();
    applyStimulus(0, 5'd0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      checkOutput("lit to stall", {31'd0, stall_m}, (i == TIMEOUT - 1) ? 0 : 1);
      checkOutput("lit to req",   {31'd0, dmem_req}, 1);
      tick();
    end
    @(negedge clk);
    checkOutput("lit to req off", {31'd0, dmem_req},    0);
    checkOutput("lit to err",     {31'd0, bus_err_m},   1);
    checkOutput("lit to valid_w", {31'd0, valid_w},     1);
    checkOutput("lit to rw",      {31'd0, reg_write_w}, 0);
    tick();
    @(negedge clk);
    checkOutput("lit to err sticky", {31'd0, bus_err_m}, 1);
    checkOutput("lit to single",     {31'd0, valid_w},   0);

    // Reset in the middle of a wait abandons the access.
    applyStimulus(1, OP_LW, 32'hC0, 0, 5'd6, 1, 0, 0);
    tick();
    applyStimulus(0, 5'd0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    applyStimulus(0, 5'd0, 0, 0, 0, 0, 1, 32'h7777_7777);
    @(negedge clk);
    checkOutput("lit rst req",   {31'd0, dmem_req},  0);
    checkOutput("lit rst err",   {31'd0, bus_err_m}, 0);
    checkOutput("lit rst addr",  dmem_addr,          0);
    checkOutput("lit rst stall", {31'd0, stall_m},   0);
    tick();
    applyStimulus(1, 5'd3, 32'hABC, 0, 5'd2, 1, 0, 0);
    @(negedge clk);
    checkOutput("lit rst ignore", {31'd0, valid_w}, 0);
    tick();
    applyStimulus(0, 5'd0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("lit rst alu valid", {31'd0, valid_w}, 1);
    checkOutput("lit rst alu wb",    wb_data_w,        32'hABC);

    // Randomized traffic, with occasional silent-memory stretches and resets.
    noReadyLeft = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic [4:0] op;
      int pick;
      tick();
      pick = $urandom_range(0, 9);
      if (pick < 3)      op = OP_LW;
      else if (pick < 5) op = OP_SW;
      else               op = 5'($urandom_range(0, 31));
      if (noReadyLeft == 0 && $urandom_range(0, 199) == 0) noReadyLeft = 40;
      applyStimulus(1'($urandom_range(0, 3) != 0), op, $urandom, $urandom,
                    ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                    1'($urandom_range(0, 1)),
                    (noReadyLeft > 0) ? 1'b0 : 1'($urandom_range(0, 2) == 0),
                    $urandom);
      if (noReadyLeft > 0) noReadyLeft--;
      rst_n = ($urandom_range(0, 149) != 0);
    end
    rst_n = 1'b1;
    tick();
    @(negedge clk);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
